// File: rtl/bridge_input_arbiter_pkg.sv
// Shared definitions for the bridge input arbiter: FSM encoding, counter
// width and a ceiling-log2 helper used to size grant/pointer indices.
package bridge_input_arbiter_pkg;

  localparam int unsigned CNT_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_e;

  // Ceiling log2, never below 1 so a 2-input arbiter still has a 1-bit index.
  function automatic int unsigned log2_ceil(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/bridge_input_arbiter_rr_priority_encoder.sv
// Round-robin priority encoder: finds the first set request bit starting at
// ptr and searching upward, wrapping at N. Purely combinational.
//   req     : request vector, one bit per requester
//   ptr     : search start index (must be < N)
//   valid_c : at least one request set
//   idx_c   : index of the selected requester (0 when none)
module bridge_input_arbiter_rr_priority_encoder #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid_c,
  output logic [W-1:0] idx_c
);

  logic [W-1:0] cand;

  // Walk the requesters in rotated order; the first hit wins.
  always_comb begin
    valid_c = 1'b0;
    idx_c   = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = W'((32'(ptr) + k) % N);
      if (!valid_c && req[cand]) begin
        valid_c = 1'b1;
        idx_c   = cand;
      end
    end
  end

endmodule

// File: rtl/bridge_input_arbiter.sv
// Packet-granular round-robin arbiter in front of the byte-swap bridge.
// One input owns the output from grant until its tlast beat is accepted;
// beats pass through a one-deep registered output stage unmodified.
//   clk, resetn          : clock, asynchronous active-low reset
//   s_axis_*             : NUM_INPUTS little-endian AXI4-Stream sources (input i at slice i)
//   m_axis_*             : bridge slave interface (registered)
//   enable_mask          : per-input grant eligibility, sampled only while idle
//   pkt_count            : packets forwarded per input (32-bit, wrapping)
//   cur_grant            : index of the input owning the output
module bridge_input_arbiter
  import bridge_input_arbiter_pkg::*;
#(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned NUM_INPUTS         = 4,
  parameter int unsigned NUM_INPUTS_WIDTH   = log2_ceil(NUM_INPUTS)
) (
  input  logic                                      clk,
  input  logic                                      resetn,
  input  logic [NUM_INPUTS*C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_INPUTS*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [NUM_INPUTS*C_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic [NUM_INPUTS-1:0]                     s_axis_tvalid,
  output logic [NUM_INPUTS-1:0]                     s_axis_tready,
  input  logic [NUM_INPUTS-1:0]                     s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]            m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic                                      m_axis_tlast,
  input  logic [NUM_INPUTS-1:0]                     enable_mask,
  output logic [NUM_INPUTS*CNT_W-1:0]               pkt_count,
  output logic [NUM_INPUTS_WIDTH-1:0]               cur_grant
);

  localparam int unsigned DW = C_AXIS_DATA_WIDTH;
  localparam int unsigned SW = C_AXIS_DATA_WIDTH / 8;
  localparam int unsigned UW = C_AXIS_TUSER_WIDTH;
  localparam int unsigned NI = NUM_INPUTS;
  localparam int unsigned GW = NUM_INPUTS_WIDTH;

  arb_state_e    state_q;
  arb_state_e    state_d;
  logic [GW-1:0] grant_d;
  logic [GW-1:0] rr_ptr_q;
  logic [GW-1:0] rr_ptr_d;

  logic [NI-1:0] req_c;
  logic          any_req_c;
  logic [GW-1:0] pick_idx_c;

  logic [DW-1:0] sel_data_c;
  logic [SW-1:0] sel_strb_c;
  logic [UW-1:0] sel_user_c;
  logic          sel_valid_c;
  logic          sel_last_c;
  logic          out_free_c;
  logic          accept_c;

  assign req_c = s_axis_tvalid & enable_mask;

  bridge_input_arbiter_rr_priority_encoder #(
    .N (NI),
    .W (GW)
  ) u_rr_enc (
    .req     (req_c),
    .ptr     (rr_ptr_q),
    .valid_c (any_req_c),
    .idx_c   (pick_idx_c)
  );

  // Mux out the granted input's beat.
  always_comb begin
    sel_data_c  = '0;
    sel_strb_c  = '0;
    sel_user_c  = '0;
    sel_valid_c = 1'b0;
    sel_last_c  = 1'b0;
    for (int unsigned i = 0; i < NI; i++) begin
      if (GW'(i) == cur_grant) begin
        sel_data_c  = s_axis_tdata[i*DW +: DW];
        sel_strb_c  = s_axis_tstrb[i*SW +: SW];
        sel_user_c  = s_axis_tuser[i*UW +: UW];
        sel_valid_c = s_axis_tvalid[i];
        sel_last_c  = s_axis_tlast[i];
      end
    end
  end

  // Output stage can take a beat when empty or draining this cycle.
  assign out_free_c = !m_axis_tvalid || m_axis_tready;
  assign accept_c   = (state_q == PASS) && sel_valid_c && out_free_c;

  // Ready goes only to the owner, and only while it owns the output.
  always_comb begin
    s_axis_tready = '0;
    for (int unsigned i = 0; i < NI; i++) begin
      if ((state_q == PASS) && (GW'(i) == cur_grant)) begin
        s_axis_tready[i] = out_free_c;
      end
    end
  end

  // Next-state: grant in IDLE, release on the accepted tlast beat.
  always_comb begin
    state_d  = state_q;
    grant_d  = cur_grant;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (any_req_c) begin
          grant_d = pick_idx_c;
          state_d = PASS;
        end
      end
      PASS: begin
        if (accept_c && sel_last_c) begin
          state_d  = IDLE;
          rr_ptr_d = (cur_grant == GW'(NI - 1)) ? '0 : cur_grant + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cur_grant <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      cur_grant <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // One-deep output register toward the bridge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tuser  <= '0;
    end else if (accept_c) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= sel_last_c;
      m_axis_tdata  <= sel_data_c;
      m_axis_tstrb  <= sel_strb_c;
      m_axis_tuser  <= sel_user_c;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Per-input packet counters, bumped on the accepted tlast beat; wrap freely.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_count <= '0;
    end else if (accept_c && sel_last_c) begin
      for (int unsigned i = 0; i < NI; i++) begin
        if (GW'(i) == cur_grant) begin
          pkt_count[i*CNT_W +: CNT_W] <= pkt_count[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bridge_input_arbiter.sv
// Randomized scoreboard bench for bridge_input_arbiter. Sources are kept
// saturated (a source with queued packets always presents tvalid), so the
// granted order follows directly from the round-robin rule applied to the
// per-input packet lists.
module tb_bridge_input_arbiter;

  localparam int NI = 4;
  localparam int DW = 256;
  localparam int SW = 32;
  localparam int UW = 128;
  localparam int GW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NI*DW-1:0]  s_axis_tdata = '0;
  logic [NI*SW-1:0]  s_axis_tstrb = '0;
  logic [NI*UW-1:0]  s_axis_tuser = '0;
  logic [NI-1:0]     s_axis_tvalid = '0;
  logic [NI-1:0]     s_axis_tready;
  logic [NI-1:0]     s_axis_tlast = '0;
  logic [DW-1:0]     m_axis_tdata;
  logic [SW-1:0]     m_axis_tstrb;
  logic [UW-1:0]     m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              m_axis_tlast;
  logic [NI-1:0]     enable_mask = '1;
  logic [NI*32-1:0]  pkt_count;
  logic [GW-1:0]     cur_grant;

  bridge_input_arbiter #(
    .C_AXIS_DATA_WIDTH  (DW),
    .C_AXIS_TUSER_WIDTH (UW),
    .NUM_INPUTS         (NI),
    .NUM_INPUTS_WIDTH   (GW)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .enable_mask   (enable_mask),
    .pkt_count     (pkt_count),
    .cur_grant     (cur_grant)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t src_q   [NI][$];   // what each source still has to send
  beat_t mdl_q   [NI][$];   // reference model copy of the same beats
  int    mdl_len [NI][$];   // reference model packet lengths
  beat_t exp_q   [$];       // scoreboard: expected output beats in order
  int    exp_cnt [NI];
  int    mdl_ptr = 0;
  int    rdy_mode = 0;      // 0: always ready, 1: toggle, 2: random
  int    cyc = 0;
  int    hs_total = 0;
  int    last_hs = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_packet(input int i, input int len);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
      for (int w = 0; w < UW / 32; w++) b.user[w*32 +: 32] = $urandom;
      b.strb = $urandom;
      b.last = (j == len - 1);
      src_q[i].push_back(b);
      mdl_q[i].push_back(b);
    end
    mdl_len[i].push_back(len);
  endtask

  // Reference: grant the first enabled input with a pending packet,
  // searching upward from the pointer; the pointer moves past the winner.
  task automatic model_one(input logic [NI-1:0] mask, output bit found);
    int    c;
    int    len;
    beat_t b;
    found = 1'b0;
    for (int k = 0; k < NI && !found; k++) begin
      c = (mdl_ptr + k) % NI;
      if (mask[c] && mdl_len[c].size() != 0) begin
        len = mdl_len[c].pop_front();
        for (int j = 0; j < len; j++) begin
          b = mdl_q[c].pop_front();
          exp_q.push_back(b);
        end
        exp_cnt[c]++;
        mdl_ptr = (c + 1) % NI;
        found = 1'b1;
      end
    end
  endtask

  task automatic model_all(input logic [NI-1:0] mask);
    bit f;
    f = 1'b1;
    while (f) model_one(mask, f);
  endtask

  task automatic flush_sources();
    for (int i = 0; i < NI; i++) begin
      src_q[i].delete();
      mdl_q[i].delete();
      mdl_len[i].delete();
    end
  endtask

  task automatic present();
    beat_t b;
    for (int i = 0; i < NI; i++) begin
      if (src_q[i].size() != 0) begin
        b = src_q[i][0];
        s_axis_tvalid[i] = 1'b1;
      end else begin
        b = '0;
        s_axis_tvalid[i] = 1'b0;
      end
      s_axis_tdata[i*DW +: DW] = b.data;
      s_axis_tstrb[i*SW +: SW] = b.strb;
      s_axis_tuser[i*UW +: UW] = b.user;
      s_axis_tlast[i]          = b.last;
    end
  endtask

  // Caller sits at a falling edge; asserts reset mid-cycle and checks reset state.
  task automatic do_reset(input string tag);
    #2 resetn = 1'b0;
    #1;
    check({tag, " m_tvalid"}, m_axis_tvalid, 0);
    check({tag, " m_tlast"}, m_axis_tlast, 0);
    check({tag, " m_tdata"}, m_axis_tdata, 0);
    check({tag, " pkt_count"}, pkt_count, 0);
    check({tag, " cur_grant"}, cur_grant, 0);
    check({tag, " s_tready"}, s_axis_tready, 0);
    flush_sources();
    exp_q.delete();
    for (int i = 0; i < NI; i++) exp_cnt[i] = 0;
    mdl_ptr = 0;
    @(negedge clk);
    #2 resetn = 1'b1;
  endtask

  task automatic sync_pos();
    @(posedge clk);
    #2;
  endtask

  task automatic finish_phase(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: got %0d beats outstanding expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    flush_sources();
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++)
      check($sformatf("%s pkt_count[%0d]", tag, i), pkt_count[i*32 +: 32], exp_cnt[i]);
  endtask

  // Source driver: pop accepted beats, present the next head, drive m_axis_tready.
  initial begin : driver
    logic [NI-1:0] acc;
    beat_t         tmp;
    forever begin
      @(negedge clk);
      acc = s_axis_tvalid & s_axis_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++)
        if (acc[i] && src_q[i].size() != 0) tmp = src_q[i].pop_front();
      present();
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = ($urandom_range(0, 99) < 60);
      endcase
    end
  end

  // Monitor: pop and compare on every output handshake; protocol checks each cycle.
  initial begin : monitor
    beat_t got;
    beat_t want;
    beat_t prev_beat;
    logic  prev_stall;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (resetn) begin
        got = {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast};
        if (prev_stall) begin
          check("hold_valid", m_axis_tvalid, 1);
          check("hold_data", got, prev_beat);
        end
        if (m_axis_tvalid && !m_axis_tready)
          check("src_ready_while_full", s_axis_tready, 0);
        check("ready_onehot", ($countones(s_axis_tready) > 1), 0);
        if (m_axis_tvalid && m_axis_tready) begin
          hs_total++;
          last_hs = cyc;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: got %0h expected no beat", got);
          end else begin
            want = exp_q.pop_front();
            check("beat", got, want);
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_beat  = got;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    int first;
    int base;
    bit f;

    repeat (2) @(negedge clk);
    do_reset("init");

    // Reset during beat 2 of a 4-beat packet on input 2.
    sync_pos();
    rdy_mode = 0;
    enable_mask = '1;
    add_packet(2, 4);
    model_all('1);
    n = 0;
    while (src_q[2].size() != 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid reached beat 2", (n < 50), 1);
    check("rst_mid pre valid", m_axis_tvalid, 1);
    do_reset("rst_mid");

    // Fairness: 25 two-beat packets per input, always ready, starts at input 0.
    sync_pos();
    for (int p = 0; p < 25; p++)
      for (int i = 0; i < NI; i++) add_packet(i, 2);
    model_all('1);
    base = hs_total;
    n = 0;
    while (hs_total == base && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    first = last_hs;
    finish_phase("fair");
    check("fair span cycles", last_hs - first, 298);

    // Backpressure: 8-beat packet on input 2 with tready toggling.
    sync_pos();
    rdy_mode = 1;
    add_packet(2, 8);
    model_all('1);
    finish_phase("bp");
    rdy_mode = 0;

    // Mask 1010 with all inputs valid: 1 and 3 alternate.
    @(negedge clk);
    do_reset("mask_rst");
    sync_pos();
    enable_mask = 4'b1010;
    for (int i = 0; i < NI; i++) begin
      add_packet(i, 2 + (i % 2));
      add_packet(i, 3);
    end
    model_all(4'b1010);
    finish_phase("mask_alt");

    // Clear bit 1 while input 1 is mid-packet; its packet still completes.
    sync_pos();
    for (int p = 0; p < 3; p++) begin
      add_packet(1, 4);
      add_packet(3, 4);
    end
    add_packet(0, 2);
    add_packet(2, 2);
    model_one(4'b1010, f);
    n = 0;
    while (!s_axis_tready[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mask_mid input1 granted", (n < 50), 1);
    sync_pos();
    enable_mask = 4'b1000;
    model_all(4'b1000);
    finish_phase("mask_mid");

    // Pointer wrap: move pointer to 3, then inputs 3 and 0 with single beats.
    @(negedge clk);
    do_reset("wrap_rst");
    sync_pos();
    enable_mask = '1;
    add_packet(2, 1);
    model_all('1);
    finish_phase("wrap_pre");
    sync_pos();
    for (int p = 0; p < 3; p++) begin
      add_packet(0, 1);
      add_packet(3, 1);
    end
    model_all('1);
    finish_phase("wrap");

    // Randomized phases: random mask, packet counts, lengths and backpressure.
    for (int ph = 0; ph < 6; ph++) begin
      sync_pos();
      rdy_mode = 2;
      enable_mask = NI'($urandom_range(1, 15));
      for (int i = 0; i < NI; i++) begin
        n = $urandom_range(0, 3);
        for (int p = 0; p < n; p++) add_packet(i, $urandom_range(1, 5));
      end
      model_all(enable_mask);
      finish_phase($sformatf("rand%0d", ph));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bridge_input_arbiter.md
# bridge_input_arbiter

Packet-granular round-robin arbiter sharing one little-to-big-endian byte-swap bridge between NUM_INPUTS little-endian AXI4-Stream sources. Sits directly upstream of the bridge: selects one input per packet, holds the grant until that packet's tlast beat is accepted, and drives the bridge slave interface through a one-deep registered output stage. Also keeps per-input packet counters for the register block.

## Interface
- C_AXIS_DATA_WIDTH, 256, tdata width per input and output
- C_AXIS_TUSER_WIDTH, 128, tuser width per input and output
- NUM_INPUTS, 4, number of requesters (2..8)
- NUM_INPUTS_WIDTH, log2(NUM_INPUTS), grant index width
- clk  in  1  single clock
- resetn  in  1  asynchronous, active-low reset
- s_axis_tdata  in  NUM_INPUTS*C_AXIS_DATA_WIDTH  input i at slice i
- s_axis_tstrb  in  NUM_INPUTS*C_AXIS_DATA_WIDTH/8  per-input byte strobes
- s_axis_tuser  in  NUM_INPUTS*C_AXIS_TUSER_WIDTH  per-input sideband
- s_axis_tvalid  in  NUM_INPUTS  per-input valid
- s_axis_tready  out  NUM_INPUTS  per-input ready
- s_axis_tlast  in  NUM_INPUTS  per-input end of packet
- m_axis_tdata/tstrb/tuser/tvalid/tlast  out  as bridge slave  to bridge
- m_axis_tready  in  1  from bridge
- enable_mask  in  NUM_INPUTS  1 = input eligible for grant
- pkt_count  out  NUM_INPUTS*32  packets forwarded per input
- cur_grant  out  NUM_INPUTS_WIDTH  index of input owning the output

## Operation
- FSM states IDLE, PASS.
- IDLE: request vector = s_axis_tvalid & enable_mask. If nonzero, grant = first set bit searching from rr_ptr upward, wrapping at NUM_INPUTS; register cur_grant, go PASS. Else stay.
- PASS: only input cur_grant may see ready. Beat accept condition: s_axis_tvalid[g] && s_axis_tready[g].
- s_axis_tready[g] = (state==PASS) && (!m_axis_tvalid || m_axis_tready); all other bits 0. Combinational from m_axis_tready.
- Output register loads tdata/tstrb/tuser/tlast of input g on accept and sets m_axis_tvalid; clears m_axis_tvalid when m_axis_tready and no new accept. Data unmodified (swap is the bridge's job).
- Accept of tlast beat: state -> IDLE, rr_ptr <= (g+1) mod NUM_INPUTS, pkt_count[g] increments.
- enable_mask sampled only in IDLE; deasserting mid-packet never aborts the current packet.
- pkt_count wraps 0xFFFFFFFF -> 0, no saturation.

## Timing
- Reset (resetn low, async): state IDLE, rr_ptr 0, cur_grant 0, m_axis_tvalid/tlast 0, m_axis_tdata/tstrb/tuser 0, s_axis_tready 0, all pkt_count 0. Mid-packet reset discards the packet; output deasserts immediately.
- Arbitration: 1 cycle in IDLE per packet; first beat accepted earliest cycle after grant; one bubble between back-to-back packets.
- Latency: accepted beat appears on m_axis the next cycle.
- Throughput inside a packet: 1 beat/cycle while m_axis_tready high.
- m_axis_tvalid, once high, holds with stable data until m_axis_tready.
- Single-beat packet (tvalid and tlast on first beat): PASS lasts one cycle.
- rr_ptr ignores requests arriving during PASS until IDLE.
- NUM_INPUTS not a power of two: pointer wraps at NUM_INPUTS, never beyond.

## Structure
- Shared include/package: FSM state encodings (IDLE=0, PASS=1), log2 function, counter width constant (32).
- One sub-module natural: rr_priority_encoder (request vector + pointer -> valid + index), combinational, reusable by other NetFPGA arbiters.
- Output register stage inline in the top module.

## Test plan
- Reset mid-packet: assert resetn low during beat 2 of a 4-beat packet -> m_axis_tvalid 0 same cycle, pkt_count all 0, after release first grant goes to input 0.
- Fairness: inputs 0..3 each continuously offer 2-beat packets, m_axis_tready=1 -> output order 0,1,2,3,0,... with one idle cycle between packets; each pkt_count = 25 after 100 packets.
- Backpressure: m_axis_tready toggles 1/0 each cycle during an 8-beat packet on input 2 -> all 8 beats delivered in order, no duplication, s_axis_tready[2] low whenever output full and not draining.
- Mask: enable_mask=4'b1010 with all inputs valid -> only inputs 1 and 3 granted, alternating; clear bit 1 mid-packet from input 1 -> packet completes, then only input 3.
- Pointer wrap: only input 3 then input 0 requesting, rr_ptr=3 -> grant 3, then 0; single-beat packets each cycle -> pkt_count[3] and [0] increment once per packet.
- Counter wrap: force pkt_count[1]=0xFFFFFFFF, forward one packet on input 1 -> reads 0x00000000.
